// File: rtl/fft_frame_ctrl.sv
// Frame sequencer in front of fft_top: loads N samples into the four RAM banks, pulses start,
// waits for ready, then streams the N results out in bank-interleaved order.
module fft_frame_ctrl #(
    parameter int N       = 4096,
    parameter int N_BANK  = N / 4,
    parameter int D_BIT   = 16,
    parameter int A_BIT   = $clog2(N_BANK),
    parameter int RD_LAT  = 2,
    parameter int TIMEOUT = 65535
) (
    input  logic                 iCLK,
    input  logic                 iRESET,
    input  logic                 iEN,
    input  logic [D_BIT-2:0]     iSAMPLE,
    input  logic                 iSAMPLE_VALID,
    output logic                 oSAMPLE_READY,
    output logic [D_BIT-2:0]     oDATA,
    output logic [A_BIT-1:0]     oADDR_WR_0,
    output logic [A_BIT-1:0]     oADDR_WR_1,
    output logic [A_BIT-1:0]     oADDR_WR_2,
    output logic [A_BIT-1:0]     oADDR_WR_3,
    output logic                 oWE_0,
    output logic                 oWE_1,
    output logic                 oWE_2,
    output logic                 oWE_3,
    output logic                 oSTART,
    input  logic                 iFFT_RDY,
    output logic [A_BIT-1:0]     oADDR_RD_0,
    output logic [A_BIT-1:0]     oADDR_RD_1,
    output logic [A_BIT-1:0]     oADDR_RD_2,
    output logic [A_BIT-1:0]     oADDR_RD_3,
    input  logic [D_BIT-1:0]     iFFT_RE_0,
    input  logic [D_BIT-1:0]     iFFT_RE_1,
    input  logic [D_BIT-1:0]     iFFT_RE_2,
    input  logic [D_BIT-1:0]     iFFT_RE_3,
    input  logic [D_BIT-1:0]     iFFT_IM_0,
    input  logic [D_BIT-1:0]     iFFT_IM_1,
    input  logic [D_BIT-1:0]     iFFT_IM_2,
    input  logic [D_BIT-1:0]     iFFT_IM_3,
    output logic [D_BIT-1:0]     oOUT_RE,
    output logic [D_BIT-1:0]     oOUT_IM,
    output logic [$clog2(N)-1:0] oOUT_IDX,
    output logic                 oOUT_VALID,
    output logic                 oBUSY,
    output logic                 oERR,
    output logic [2:0]           oSTATE
);
    localparam int L  = $clog2(N);
    localparam int UW = L + 1;

    // Sample handshake: a sample transfers on a rising edge where iSAMPLE_VALID and
    // oSAMPLE_READY are both high; the result stream has a strobe only, no backpressure.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_KICK   = 3'd2,
        S_WAIT   = 3'd3,
        S_UNLOAD = 3'd4
    } state_t;

    state_t           state, state_d;
    logic [UW-1:0]    scnt;
    logic [15:0]      tcnt;
    logic [UW-1:0]    ucnt;
    logic [L-1:0]     m_idx;
    logic [A_BIT-1:0] wr_addr;
    logic [3:0]       we;
    logic [D_BIT-1:0] cap_re1, cap_re2, cap_re3;
    logic [D_BIT-1:0] cap_im1, cap_im2, cap_im3;
    logic             accept, rdy_ok, timeout, unload_done;

    assign accept      = (state == S_LOAD) && iSAMPLE_VALID;
    // The first two WAIT cycles mask a ready left over from the previous frame.
    assign rdy_ok      = (state == S_WAIT) && (tcnt >= 16'd2) && iFFT_RDY;
    assign timeout     = (state == S_WAIT) && !rdy_ok && (tcnt == 16'(TIMEOUT - 1));
    assign unload_done = (state == S_UNLOAD) && (ucnt == UW'(N + RD_LAT - 1));
    assign m_idx       = L'(ucnt - UW'(RD_LAT));

    assign oSAMPLE_READY = (state == S_LOAD);
    assign oSTATE        = state;
    assign {oWE_3, oWE_2, oWE_1, oWE_0} = we;
    assign oADDR_WR_0 = wr_addr;
    assign oADDR_WR_1 = wr_addr;
    assign oADDR_WR_2 = wr_addr;
    assign oADDR_WR_3 = wr_addr;
    assign oADDR_RD_0 = ((state == S_UNLOAD) && (ucnt < UW'(N))) ? ucnt[L-1:2] : '0;
    assign oADDR_RD_1 = oADDR_RD_0;
    assign oADDR_RD_2 = oADDR_RD_0;
    assign oADDR_RD_3 = oADDR_RD_0;

    always_ff @(posedge iCLK) begin
        if (!iRESET) state <= S_IDLE;
        else         state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:   if (iEN && !oERR) state_d = S_LOAD;
            S_LOAD:   if (accept && (scnt == UW'(N - 1))) state_d = S_KICK;
            S_KICK:   state_d = S_WAIT;
            S_WAIT:   if (rdy_ok) state_d = S_UNLOAD;
                      else if (timeout) state_d = S_IDLE;
            S_UNLOAD: if (unload_done) state_d = iEN ? S_LOAD : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            scnt       <= '0;
            tcnt       <= '0;
            ucnt       <= '0;
            oDATA      <= '0;
            wr_addr    <= '0;
            we         <= '0;
            oSTART     <= 1'b0;
            oBUSY      <= 1'b0;
            oERR       <= 1'b0;
            oOUT_VALID <= 1'b0;
            oOUT_IDX   <= '0;
            oOUT_RE    <= '0;
            oOUT_IM    <= '0;
            cap_re1 <= '0; cap_re2 <= '0; cap_re3 <= '0;
            cap_im1 <= '0; cap_im2 <= '0; cap_im3 <= '0;
        end else begin
            we         <= '0;
            oSTART     <= (state == S_KICK);
            oBUSY      <= (state_d != S_IDLE);
            oOUT_VALID <= 1'b0;

            if (state != S_LOAD) begin
                scnt <= '0;
            end else if (accept) begin
                oDATA   <= iSAMPLE;
                wr_addr <= scnt[A_BIT-1:0];
                we      <= 4'b0001 << scnt[L-1:A_BIT];
                scnt    <= scnt + 1'b1;
            end

            if (state != S_WAIT)               tcnt <= '0;
            else if (tcnt != 16'(TIMEOUT))     tcnt <= tcnt + 16'd1;
            if (timeout) oERR <= 1'b1;

            if (state_d != S_UNLOAD)   ucnt <= '0;
            else if (state == S_UNLOAD) ucnt <= ucnt + 1'b1;

            // Bank 0 goes straight out; banks 1..3 come from the copy taken that same cycle.
            if ((state == S_UNLOAD) && (ucnt >= UW'(RD_LAT))) begin
                oOUT_VALID <= 1'b1;
                oOUT_IDX   <= m_idx;
                case (m_idx[1:0])
                    2'd0: begin
                        oOUT_RE <= iFFT_RE_0; oOUT_IM <= iFFT_IM_0;
                        cap_re1 <= iFFT_RE_1; cap_im1 <= iFFT_IM_1;
                        cap_re2 <= iFFT_RE_2; cap_im2 <= iFFT_IM_2;
                        cap_re3 <= iFFT_RE_3; cap_im3 <= iFFT_IM_3;
                    end
                    2'd1: begin oOUT_RE <= cap_re1; oOUT_IM <= cap_im1; end
                    2'd2: begin oOUT_RE <= cap_re2; oOUT_IM <= cap_im2; end
                    default: begin oOUT_RE <= cap_re3; oOUT_IM <= cap_im3; end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with a small frame (N=256) and a latency-2 model of the fft_top result RAM.
module tb_fft_frame_ctrl;
    localparam int N  = 256;
    localparam int NB = N / 4;
    localparam int D  = 16;
    localparam int A  = 6;
    localparam int L  = 8;
    localparam int TO = 300;
    localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_KICK = 3'd2, S_WAIT = 3'd3, S_UNLOAD = 3'd4;

    logic clk = 1'b0;
    logic rst_n, en, smp_valid, fft_rdy;
    logic [D-2:0] smp;
    logic smp_ready, start, out_valid, busy, err;
    logic [D-2:0] data;
    logic [A-1:0] awr0, awr1, awr2, awr3, ard0, ard1, ard2, ard3;
    logic we0, we1, we2, we3;
    logic [D-1:0] re0, re1, re2, re3, im0, im1, im2, im3, out_re, out_im;
    logic [L-1:0] out_idx;
    logic [2:0] state;
    logic [3:0] we;
    logic [A-1:0] rd_d1, rd_d2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fft_frame_ctrl #(.N(N), .D_BIT(D), .A_BIT(A), .RD_LAT(2), .TIMEOUT(TO)) dut (
        .iCLK(clk), .iRESET(rst_n), .iEN(en),
        .iSAMPLE(smp), .iSAMPLE_VALID(smp_valid), .oSAMPLE_READY(smp_ready),
        .oDATA(data),
        .oADDR_WR_0(awr0), .oADDR_WR_1(awr1), .oADDR_WR_2(awr2), .oADDR_WR_3(awr3),
        .oWE_0(we0), .oWE_1(we1), .oWE_2(we2), .oWE_3(we3),
        .oSTART(start), .iFFT_RDY(fft_rdy),
        .oADDR_RD_0(ard0), .oADDR_RD_1(ard1), .oADDR_RD_2(ard2), .oADDR_RD_3(ard3),
        .iFFT_RE_0(re0), .iFFT_RE_1(re1), .iFFT_RE_2(re2), .iFFT_RE_3(re3),
        .iFFT_IM_0(im0), .iFFT_IM_1(im1), .iFFT_IM_2(im2), .iFFT_IM_3(im3),
        .oOUT_RE(out_re), .oOUT_IM(out_im), .oOUT_IDX(out_idx), .oOUT_VALID(out_valid),
        .oBUSY(busy), .oERR(err), .oSTATE(state)
    );

    assign we = {we3, we2, we1, we0};

    // Result RAM model: bank b at address a holds RE=b*1000+a, IM=-RE, two-cycle read latency.
    always @(posedge clk) begin
        rd_d1 <= ard0;
        rd_d2 <= rd_d1;
    end
    assign re0 = D'(rd_d2);
    assign re1 = D'(1000) + D'(rd_d2);
    assign re2 = D'(2000) + D'(rd_d2);
    assign re3 = D'(3000) + D'(rd_d2);
    assign im0 = -re0;
    assign im1 = -re1;
    assign im2 = -re2;
    assign im3 = -re3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int k, wk;
        logic prev;
        logic [D-1:0] e_re, e_im;

        rst_n = 1'b0; en = 1'b0; smp_valid = 1'b0; smp = '0; fft_rdy = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_state", state, S_IDLE);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", smp_ready, 0);
        chk("rst_we", we, 0);
        chk("rst_start", start, 0);
        chk("rst_valid", out_valid, 0);

        // Constant 100 with valid held high; ready held high into the WAIT mask
        rst_n = 1'b1; en = 1'b1; smp_valid = 1'b1; smp = 15'd100; fft_rdy = 1'b1;
        @(negedge clk);
        chk("load_state", state, S_LOAD);
        chk("load_ready", smp_ready, 1);
        chk("load_we0", we, 0);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            chk("c_we", we, 32'(1) << (i / NB));
            chk("c_addr", awr0, i % NB);
            chk("c_data", data, 100);
        end
        smp_valid = 1'b0;
        chk("c_kick_state", state, S_KICK);
        chk("c_kick_ready", smp_ready, 0);
        chk("c_kick_addr3", awr3, NB - 1);
        @(negedge clk);
        chk("c_start", start, 1);
        chk("c_start_we", we, 0);
        chk("c_w0_state", state, S_WAIT);
        @(negedge clk);
        chk("c_start_once", start, 0);
        chk("mask_w1", state, S_WAIT);
        @(negedge clk);
        chk("mask_w2", state, S_WAIT);
        fft_rdy = 1'b0;
        for (int i = 3; i < 50; i++) begin
            @(negedge clk);
            chk("wait_hold", state, S_WAIT);
        end
        fft_rdy = 1'b1;
        @(negedge clk);
        chk("unload_enter", state, S_UNLOAD);
        chk("unload_busy", busy, 1);
        en = 1'b0;

        // Unload stream against the RAM model
        repeat (2) @(negedge clk);
        for (int m = 0; m < N; m++) begin
            @(negedge clk);
            e_re = D'((m % 4) * 1000 + m / 4);
            e_im = -e_re;
            chk("u_valid", out_valid, 1);
            chk("u_idx", out_idx, m);
            chk("u_re", out_re, e_re);
            chk("u_im", out_im, e_im);
            if (m + 3 < N) begin
                chk("u_ard0", ard0, (m + 3) / 4);
                chk("u_ard3", ard3, (m + 3) / 4);
            end
        end
        chk("u_last_re", out_re, 3063);
        chk("u_end_state", state, S_IDLE);
        chk("u_end_busy", busy, 0);
        @(negedge clk);
        chk("u_after_valid", out_valid, 0);

        // Ramp with valid toggling every cycle
        en = 1'b1;
        @(negedge clk);
        chk("r_state", state, S_LOAD);
        smp_valid = 1'b1; smp = '0; k = 1; wk = 0; prev = 1'b1;
        for (int cyc = 0; cyc < 2 * N + 8; cyc++) begin
            @(negedge clk);
            if (prev) begin
                chk("r_we", we, 32'(1) << (wk / NB));
                chk("r_addr", awr0, wk % NB);
                chk("r_data", data, wk);
                wk++;
            end else begin
                chk("r_gap_we", we, 0);
            end
            if (wk == N) break;
            if (k < N && !smp_valid) begin
                smp_valid = 1'b1; smp = (D-1)'(k); k++; prev = 1'b1;
            end else begin
                smp_valid = 1'b0; prev = 1'b0;
            end
        end
        smp_valid = 1'b0;
        chk("r_count", wk, N);
        chk("r_kick", state, S_KICK);
        @(negedge clk);
        chk("r_start", start, 1);
        @(negedge clk);
        chk("r_mask_w1", state, S_WAIT);
        @(negedge clk);
        chk("r_mask_w2", state, S_WAIT);
        @(negedge clk);
        chk("r_unload", state, S_UNLOAD);
        repeat (N + 2) @(negedge clk);
        chk("r_last_idx", out_idx, N - 1);
        chk("r_last_valid", out_valid, 1);
        chk("r_reload", state, S_LOAD);
        fft_rdy = 1'b0;

        // Reset in the middle of a load
        smp_valid = 1'b1; smp = 15'd55;
        repeat (100) @(negedge clk);
        chk("x_we_99", we, 2);
        chk("x_addr_99", awr0, 35);
        rst_n = 1'b0;
        @(negedge clk);
        chk("x_we", we, 0);
        chk("x_start", start, 0);
        chk("x_busy", busy, 0);
        chk("x_ready", smp_ready, 0);
        chk("x_data", data, 0);
        chk("x_state", state, S_IDLE);
        rst_n = 1'b1; smp = 15'd7;
        @(negedge clk);
        chk("x_reload", state, S_LOAD);
        chk("x_reload_we", we, 0);
        @(negedge clk);
        chk("x_first_we", we, 1);
        chk("x_first_addr", awr0, 0);
        chk("x_first_data", data, 7);

        // Timeout with ready never asserted
        repeat (N - 1) @(negedge clk);
        smp_valid = 1'b0;
        chk("t_last_we", we, 8);
        chk("t_last_addr", awr3, NB - 1);
        @(negedge clk);
        chk("t_start", start, 1);
        repeat (TO - 1) @(negedge clk);
        chk("t_pre_err", err, 0);
        chk("t_pre_state", state, S_WAIT);
        @(negedge clk);
        chk("t_err", err, 1);
        chk("t_idle", state, S_IDLE);
        chk("t_busy", busy, 0);
        repeat (5) @(negedge clk);
        chk("t_err_sticky", err, 1);
        chk("t_stay_idle", state, S_IDLE);
        chk("t_no_ready", smp_ready, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t_err_clear", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
